// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 3-bit operation codes driven on the Mode input of univ_shift_reg.
package usr_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_INV  = 3'b111;

endpackage

// File: rtl/dff_en_rst.sv
// One-bit edge-triggered storage cell with clock enable and synchronous
// active-low reset.
//   clk_i  : clock, state changes on the rising edge
//   rst_ni : synchronous active-low reset, loads RstVal; wins over en_i
//   en_i   : enable, low holds the stored bit
//   d_i    : next value, captured when enabled
//   q_o    : stored bit
//   qn_o   : complement of the stored bit
module dff_en_rst #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic d_i,
    output logic q_o,
    output logic qn_o
);

    logic q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= RstVal;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o  = q_q;
    assign qn_o = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register built from per-bit storage cells.
// Supports hold, shift right/left with serial fill, parallel load, rotate
// right/left, clear and invert, selected by Mode each enabled edge.
//   CLK       : clock, rising edge
//   RSTn      : synchronous active-low reset, loads RESET_VAL
//   En        : clock enable, low holds Q
//   Mode      : operation select (usr_pkg MODE_*)
//   D         : parallel load data
//   SerR      : serial bit entering the MSB on shift right
//   SerL      : serial bit entering the LSB on shift left
//   Q / Qn    : register contents and their complement
//   SOutR     : Q[0], the bit leaving on shift right
//   SOutL     : Q[WIDTH-1], the bit leaving on shift left
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              En,
    input  logic [MODE_W-1:0] Mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              SerR,
    input  logic              SerL,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qn,
    output logic              SOutR,
    output logic              SOutL
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] ror_val;
    logic [WIDTH-1:0] rol_val;

    // A single-bit register has no neighbours: shifts take the serial input
    // directly and rotates degenerate to hold. Kept in a separate branch so
    // no [WIDTH-1:1] style slice is ever elaborated for WIDTH == 1.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign shr_val = SerR;
            assign shl_val = SerL;
            assign ror_val = q;
            assign rol_val = q;
        end else begin : g_wide
            assign shr_val = {SerR, q[WIDTH-1:1]};
            assign shl_val = {q[WIDTH-2:0], SerL};
            assign ror_val = {q[0], q[WIDTH-1:1]};
            assign rol_val = {q[WIDTH-2:0], q[WIDTH-1]};
        end
    endgenerate

    always_comb begin
        q_next = q;
        unique case (Mode)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = shr_val;
            MODE_SHL:  q_next = shl_val;
            MODE_LOAD: q_next = D;
            MODE_ROR:  q_next = ror_val;
            MODE_ROL:  q_next = rol_val;
            MODE_CLR:  q_next = '0;
            MODE_INV:  q_next = ~q;
            default:   q_next = q;
        endcase
    end

    // Reset and enable are handled inside each cell, so reset beats hold and
    // hold beats the mode mux without extra gating here.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            dff_en_rst #(
                .RstVal (RESET_VAL[i])
            ) u_cell (
                .clk_i  (CLK),
                .rst_ni (RSTn),
                .en_i   (En),
                .d_i    (q_next[i]),
                .q_o    (q[i]),
                .qn_o   (Qn[i])
            );
        end
    endgenerate

    assign Q     = q;
    assign SOutR = q[0];
    assign SOutL = q[WIDTH-1];

endmodule
